// File: rtl/hv_query_loader.sv
// Assembles NUM_CHUNKS chunks into one query hypervector and presents it with valid/ready;
// valid rises the cycle after the last chunk, and no chunks are taken while a vector is presented.
module hv_query_loader #(
    parameter int HV_DIMENSION = 2000,
    parameter int CHUNK_WIDTH  = 250,
    localparam int NUM_CHUNKS  = HV_DIMENSION / CHUNK_WIDTH,
    localparam int CNT_WIDTH   = $clog2(NUM_CHUNKS + 1)
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:CHUNK_WIDTH-1]  ChunkIn_DI,
    input  logic                    Clear_SI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] HypervectorOut_DO,
    output logic [CNT_WIDTH-1:0]    ChunkCount_DO
);

    typedef enum logic [1:0] {
        LOAD          = 2'd0,
        OUTPUT_STABLE = 2'd1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_WIDTH-1:0]    counter;
    logic [CNT_WIDTH-1:0]    counter_next;
    logic [0:HV_DIMENSION-1] buffer;
    logic                    accept;
    logic                    last_chunk;

    assign last_chunk = (counter == CNT_WIDTH'(NUM_CHUNKS - 1));

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state   <= LOAD;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // Handshake outputs depend only on the registered state, never on the inputs.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        ReadyOut_SO  = 1'b0;
        ValidOut_SO  = 1'b0;
        accept       = 1'b0;
        case (state)
            LOAD: begin
                ReadyOut_SO = 1'b1;
                if (Clear_SI) begin
                    counter_next = '0;
                end else if (ValidIn_SI) begin
                    accept = 1'b1;
                    if (last_chunk) begin
                        counter_next = '0;
                        state_next   = OUTPUT_STABLE;
                    end else begin
                        counter_next = counter + CNT_WIDTH'(1);
                    end
                end
            end
            OUTPUT_STABLE: begin
                ValidOut_SO = 1'b1;
                if (ReadyIn_SI) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next   = LOAD;
                counter_next = '0;
            end
        endcase
    end

    // Chunk k fills bits [k*CHUNK_WIDTH +: CHUNK_WIDTH], so chunk 0 ends up on the MSB side.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            buffer <= '0;
        end else begin
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                if (accept && (counter == CNT_WIDTH'(i))) begin
                    buffer[i*CHUNK_WIDTH +: CHUNK_WIDTH] <= ChunkIn_DI;
                end
            end
        end
    end

    assign HypervectorOut_DO = buffer;
    assign ChunkCount_DO     = counter;

endmodule

// File: tb/tb_hv_query_loader.sv
// Bench for hv_query_loader at 16-bit vectors built from four 4-bit chunks.
module tb_hv_query_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vin = 1'b0;
    logic        rdy;
    logic [0:3]  chunk = 4'h0;
    logic        clr = 1'b0;
    logic        vld;
    logic        rin = 1'b0;
    logic [0:15] hv;
    logic [2:0]  cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hv_query_loader #(
        .HV_DIMENSION(16),
        .CHUNK_WIDTH (4)
    ) dut (
        .Clk_CI           (clk),
        .Reset_RI         (rst),
        .ValidIn_SI       (vin),
        .ReadyOut_SO      (rdy),
        .ChunkIn_DI       (chunk),
        .Clear_SI         (clr),
        .ValidOut_SO      (vld),
        .ReadyIn_SI       (rin),
        .HypervectorOut_DO(hv),
        .ChunkCount_DO    (cnt)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic [3:0]  c;
        logic        cl;
        logic        ri;
        logic        ck;
        logic        e_rdy;
        logic        e_vld;
        logic [2:0]  e_cnt;
        logic        ck_hv;
        logic [15:0] e_hv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(logic r, logic v, logic [3:0] c, logic cl, logic ri,
                                 logic ck, logic er, logic ev, logic [2:0] ec,
                                 logic ch, logic [15:0] eh);
        vec_t x;
        x.r = r; x.v = v; x.c = c; x.cl = cl; x.ri = ri;
        x.ck = ck; x.e_rdy = er; x.e_vld = ev; x.e_cnt = ec; x.ck_hv = ch; x.e_hv = eh;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs read right after reflect the current cycle.
    task automatic drive(input logic r, input logic v, input logic [3:0] c,
                         input logic cl, input logic ri);
        @(negedge clk);
        rst = r; vin = v; chunk = c; clr = cl; rin = ri;
    endtask

    logic [3:0]  seq_a5f0 [4];
    logic [3:0]  stream   [8];
    logic [3:0]  q[$];
    logic        presenting;
    logic [15:0] vec;
    int          idx;
    int          nvld;

    initial begin
        // cols: rst vin chunk clr rin | check rdy vld cnt check_hv hv
        tbl.push_back(row(1, 0, 4'h0, 0, 0,  0, 0, 0, 0, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'hA, 0, 1,  1, 1, 0, 0, 1, 16'h0000));
        tbl.push_back(row(0, 1, 4'h5, 0, 1,  1, 1, 0, 1, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'hF, 0, 1,  1, 1, 0, 2, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'h0, 0, 1,  1, 1, 0, 3, 0, 16'h0000));
        tbl.push_back(row(0, 0, 4'h0, 0, 1,  1, 0, 1, 0, 1, 16'hA5F0));
        tbl.push_back(row(0, 0, 4'h0, 0, 1,  1, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(row(0, 0, 4'h0, 0, 1,  1, 1, 0, 0, 0, 16'h0000));
        // clear together with a chunk drops that chunk
        tbl.push_back(row(0, 1, 4'h1, 0, 1,  1, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'h2, 0, 1,  1, 1, 0, 1, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'h3, 1, 1,  1, 1, 0, 2, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'hC, 0, 1,  1, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'hA, 0, 1,  1, 1, 0, 1, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'hF, 0, 1,  1, 1, 0, 2, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'hE, 0, 1,  1, 1, 0, 3, 0, 16'h0000));
        tbl.push_back(row(0, 0, 4'h0, 0, 0,  1, 0, 1, 0, 1, 16'hCAFE));
        tbl.push_back(row(0, 0, 4'h0, 0, 1,  1, 0, 1, 0, 1, 16'hCAFE));
        tbl.push_back(row(0, 0, 4'h0, 0, 0,  1, 1, 0, 0, 0, 16'h0000));
        // reset after three accepted chunks
        tbl.push_back(row(0, 1, 4'h7, 0, 0,  1, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'h7, 0, 0,  1, 1, 0, 1, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'h7, 0, 0,  1, 1, 0, 2, 0, 16'h0000));
        tbl.push_back(row(1, 1, 4'h7, 0, 0,  1, 1, 0, 3, 0, 16'h0000));
        tbl.push_back(row(0, 0, 4'h0, 0, 0,  1, 1, 0, 0, 1, 16'h0000));
        // reset while presenting
        tbl.push_back(row(0, 1, 4'h9, 0, 0,  1, 1, 0, 0, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'h9, 0, 0,  1, 1, 0, 1, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'h9, 0, 0,  1, 1, 0, 2, 0, 16'h0000));
        tbl.push_back(row(0, 1, 4'h9, 0, 0,  1, 1, 0, 3, 0, 16'h0000));
        tbl.push_back(row(1, 0, 4'h0, 0, 0,  1, 0, 1, 0, 1, 16'h9999));
        tbl.push_back(row(0, 0, 4'h0, 0, 0,  1, 1, 0, 0, 1, 16'h0000));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].cl, tbl[i].ri);
            if (tbl[i].ck) begin
                chk($sformatf("tbl%0d_rdy", i), 32'(rdy), 32'(tbl[i].e_rdy));
                chk($sformatf("tbl%0d_vld", i), 32'(vld), 32'(tbl[i].e_vld));
                chk($sformatf("tbl%0d_cnt", i), 32'(cnt), 32'(tbl[i].e_cnt));
                if (tbl[i].ck_hv) chk($sformatf("tbl%0d_hv", i), 32'(hv), 32'(tbl[i].e_hv));
            end
        end

        // Input gaps of two cycles: counter holds between chunks.
        seq_a5f0 = '{4'hA, 4'h5, 4'hF, 4'h0};
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, seq_a5f0[i], 0, 1);
            chk("gap_cnt", 32'(cnt), 32'(i));
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    drive(0, 0, 4'h0, 0, 1);
                    chk("gap_hold", 32'(cnt), 32'(i + 1));
                end
            end
        end
        drive(0, 0, 4'h0, 0, 1);
        chk("gap_vld", 32'(vld), 32'd1);
        chk("gap_hv", 32'(hv), 32'hA5F0);
        drive(0, 0, 4'h0, 0, 1);
        chk("gap_rdy_back", 32'(rdy), 32'd1);

        // Downstream backpressure with a busy upstream.
        drive(0, 1, 4'h1, 0, 0);
        drive(0, 1, 4'h2, 0, 0);
        drive(0, 1, 4'h3, 0, 0);
        drive(0, 1, 4'h4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 4'hE, 0, 0);
            chk("bp_rdy", 32'(rdy), 32'd0);
            chk("bp_vld", 32'(vld), 32'd1);
            chk("bp_hv", 32'(hv), 32'h1234);
        end
        drive(0, 1, 4'hE, 0, 1);
        chk("bp_hs_vld", 32'(vld), 32'd1);
        chk("bp_hs_hv", 32'(hv), 32'h1234);
        drive(0, 1, 4'hB, 0, 0);
        chk("bp_ready_again", 32'(rdy), 32'd1);
        chk("bp_cnt0", 32'(cnt), 32'd0);
        drive(0, 1, 4'hE, 0, 0);
        drive(0, 1, 4'hE, 0, 0);
        drive(0, 1, 4'hF, 0, 0);
        drive(0, 0, 4'h0, 0, 1);
        chk("beef_vld", 32'(vld), 32'd1);
        chk("beef_hv", 32'(hv), 32'hBEEF);

        // Back-to-back vectors: both sides always willing.
        drive(1, 0, 4'h0, 0, 0);
        stream = '{4'h0, 4'h0, 4'h0, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF};
        idx  = 0;
        nvld = 0;
        for (int c = 0; c < 12; c++) begin
            drive(0, idx < 8, (idx < 8) ? stream[idx] : 4'h0, 0, 1);
            if (vld) begin
                if (nvld == 0) begin
                    chk("b2b_cycle0", 32'(c), 32'd4);
                    chk("b2b_hv0", 32'(hv), 32'h0001);
                end else begin
                    chk("b2b_cycle1", 32'(c), 32'd9);
                    chk("b2b_hv1", 32'(hv), 32'hFFFF);
                end
                nvld++;
            end
            if (rdy && idx < 8) idx++;
        end
        chk("b2b_nvld", 32'(nvld), 32'd2);
        chk("b2b_consumed", 32'(idx), 32'd8);

        // Random traffic against a queue-based model of the loader.
        drive(1, 0, 4'h0, 0, 0);
        q.delete();
        presenting = 1'b0;
        vec = '0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 199) == 0);
            vin   = ($urandom_range(0, 3) != 0);
            chunk = 4'($urandom);
            clr   = ($urandom_range(0, 15) == 0);
            rin   = ($urandom_range(0, 2) == 0);
            chk("rnd_rdy", 32'(rdy), 32'(!presenting));
            chk("rnd_vld", 32'(vld), 32'(presenting));
            chk("rnd_cnt", 32'(cnt), presenting ? 32'd0 : 32'(q.size()));
            if (presenting) chk("rnd_hv", 32'(hv), 32'(vec));
            if (rst) begin
                q.delete();
                presenting = 1'b0;
            end else if (presenting) begin
                if (rin) presenting = 1'b0;
            end else if (clr) begin
                q.delete();
            end else if (vin) begin
                q.push_back(chunk);
                if (q.size() == 4) begin
                    vec = {q[0], q[1], q[2], q[3]};
                    presenting = 1'b1;
                    q.delete();
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
